// File: rtl/muu_arb_pkg.sv
// Shared definitions for the muu input arbiter: FSM encoding and beat layout.
package muu_arb_pkg;

    typedef logic [0:0] arb_state_t;

    localparam arb_state_t ST_IDLE = 1'b0;
    localparam arb_state_t ST_PKT  = 1'b1;

    localparam int MUU_BEAT_WIDTH  = 576;
    localparam int MUU_NETMETA_LSB = 512;

endpackage

// File: rtl/muu_skid_buffer.sv
// Two-entry registered output stage; head_q always drives the output.
module muu_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             push_s, pop_s;

    assign in_ready_o  = (count_q != 2'd2);
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = head_q;
    assign push_s      = in_valid_i && in_ready_o;
    assign pop_s       = out_valid_o && out_ready_i;

    // Occupancy update; the tail entry only fills when the head is stalled.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (count_q)
            2'd0: begin
                if (push_s) begin
                    head_d  = in_data_i;
                    count_d = 2'd1;
                end else begin
                    count_d = 2'd0;
                end
            end
            2'd1: begin
                case ({push_s, pop_s})
                    2'b11:   head_d = in_data_i;
                    2'b10: begin
                        tail_d  = in_data_i;
                        count_d = 2'd2;
                    end
                    2'b01:   count_d = 2'd0;
                    default: count_d = 2'd1;
                endcase
            end
            2'd2: begin
                if (pop_s) begin
                    head_d  = tail_q;
                    count_d = 2'd1;
                end else begin
                    count_d = 2'd2;
                end
            end
            default: count_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: rtl/muu_input_arbiter.sv
// Packet-atomic round-robin merge of NUM_PORTS streams into one 576-bit stream.
// Optional per-port packet counters are built when MUU_INARB_PKTCNT_EN is defined.
module muu_input_arbiter
    import muu_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = MUU_BEAT_WIDTH,
    parameter int USER_BITS  = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]          s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]          s_axis_tlast,
    output logic [NUM_PORTS-1:0]          s_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic [USER_BITS-1:0]          m_axis_tuserid,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready
`ifdef MUU_INARB_PKTCNT_EN
    ,
    output logic [NUM_PORTS*32-1:0]       pkt_count
`endif
);

    localparam int IDX_BITS = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int SKID_W   = DATA_WIDTH + USER_BITS + 1;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_PORTS - 1);

    arb_state_t            state_q, state_d;
    logic [IDX_BITS-1:0]   grant_q, grant_d;
    logic [IDX_BITS-1:0]   rr_ptr_q, rr_ptr_d;
    logic                  in_valid_s, in_ready_s, beat_last_s, beat_acc_s;
    logic [DATA_WIDTH-1:0] beat_data_s;
    logic [SKID_W-1:0]     skid_in_s, skid_out_s;

    // First requesting port at or after ptr, wrapping modulo NUM_PORTS.
    function automatic logic [IDX_BITS-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                                    input logic [IDX_BITS-1:0]  ptr);
        logic [IDX_BITS-1:0] sel;
        logic                found;
        int                  idx;
        sel   = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = (int'(ptr) + k) % NUM_PORTS;
            if (!found && req[idx]) begin
                sel   = IDX_BITS'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign in_valid_s  = (state_q == ST_PKT) && s_axis_tvalid[grant_q];
    assign beat_last_s = s_axis_tlast[grant_q];
    assign beat_data_s = s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
    assign beat_acc_s  = in_valid_s && in_ready_s;
    assign skid_in_s   = {beat_last_s, USER_BITS'(grant_q), beat_data_s};

    // Only the granted port sees ready, and only from registered state.
    always_comb begin
        s_axis_tready = '0;
        if (state_q == ST_PKT) begin
            s_axis_tready[grant_q] = in_ready_s;
        end else begin
            s_axis_tready = '0;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (|s_axis_tvalid) begin
                    grant_d = rr_pick(s_axis_tvalid, rr_ptr_q);
                    state_d = ST_PKT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PKT: begin
                if (beat_acc_s && beat_last_s) begin
                    rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_PKT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    muu_skid_buffer #(
        .WIDTH (SKID_W)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .in_data_i   (skid_in_s),
        .in_valid_i  (in_valid_s),
        .in_ready_o  (in_ready_s),
        .out_data_o  (skid_out_s),
        .out_valid_o (m_axis_tvalid),
        .out_ready_i (m_axis_tready)
    );

    assign m_axis_tlast   = skid_out_s[SKID_W-1];
    assign m_axis_tuserid = skid_out_s[DATA_WIDTH +: USER_BITS];
    assign m_axis_tdata   = skid_out_s[DATA_WIDTH-1:0];

`ifdef MUU_INARB_PKTCNT_EN
    logic [31:0] pkt_cnt_q [NUM_PORTS];

    // Counts accepted tlast beats per source; wraps naturally at 2**32.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                pkt_cnt_q[i] <= 32'd0;
            end
        end else if (beat_acc_s && beat_last_s) begin
            pkt_cnt_q[grant_q] <= pkt_cnt_q[grant_q] + 32'd1;
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
        assign pkt_count[g*32 +: 32] = pkt_cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_muu_input_arbiter.sv
// Bench for muu_input_arbiter: cycle table, directed corner cases, randomized packet traffic.
module tb_muu_input_arbiter;

    localparam int NP = 4;
    localparam int DW = 576;
    localparam int UB = 3;

    logic              clk, rst;
    logic [NP*DW-1:0]  s_tdata;
    logic [NP-1:0]     s_tvalid, s_tlast, s_tready;
    logic [DW-1:0]     m_tdata;
    logic              m_tvalid, m_tlast, m_tready;
    logic [UB-1:0]     m_tuser;
`ifdef MUU_INARB_PKTCNT_EN
    logic [NP*32-1:0]  pkt_count;
`endif

    muu_input_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .USER_BITS(UB)) dut (
        .clk            (clk),
        .rst            (rst),
        .s_axis_tdata   (s_tdata),
        .s_axis_tvalid  (s_tvalid),
        .s_axis_tlast   (s_tlast),
        .s_axis_tready  (s_tready),
        .m_axis_tdata   (m_tdata),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tuserid (m_tuser),
        .m_axis_tlast   (m_tlast),
        .m_axis_tready  (m_tready)
`ifdef MUU_INARB_PKTCNT_EN
        ,
        .pkt_count      (pkt_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct { logic [31:0] tag; logic last; } beat_t;
    typedef struct { logic [UB-1:0] user; logic last; logic [DW-1:0] data; } obs_t;
    typedef struct {
        logic [3:0] tv; logic [3:0] tl; logic [7:0] dat; logic mr;
        logic [3:0] str; logic mv; logic ml; logic [2:0] mu; logic [15:0] md;
    } vec_t;

    int      n_checks = 0;
    int      n_fail   = 0;
    beat_t   src_q [NP][$];
    obs_t    obs_q[$];
    obs_t    exp_q[$];
    logic    in_pkt [NP];
    logic    acc [NP];
    int      acc_cnt [NP];
    logic    eng_on = 1'b0;
    int      mode = 0;
    int      gap_pct = 0;
    int      pkt_seq = 0;
    logic    prev_stall = 1'b0;
    logic [DW+UB+1:0] prev_vec;
    beat_t   eb;

    function automatic logic [DW-1:0] fill(input logic [31:0] tag);
        return {(DW/32){tag}};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic chk_w(input string nm, input logic [639:0] act, input logic [639:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Source/sink engine: observe handshakes before the edge, drive after it.
    initial begin
        for (int p = 0; p < NP; p++) begin
            in_pkt[p] = 1'b0; acc[p] = 1'b0; acc_cnt[p] = 0;
        end
        forever begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                acc[p] = s_tvalid[p] && s_tready[p] && (src_q[p].size() > 0);
                if (acc[p]) begin
                    eb = src_q[p].pop_front();
                    acc_cnt[p]++;
                    in_pkt[p] = !eb.last;
                end
            end
            if (!rst) begin
                chk("tready_onehot0", 64'($onehot0(s_tready)), 64'd1);
                if (m_tvalid && m_tready) obs_q.push_back('{m_tuser, m_tlast, m_tdata});
                if (prev_stall) chk_w("stall_hold", 640'({m_tuser, m_tlast, m_tvalid, m_tdata}), 640'(prev_vec));
            end
            prev_stall = m_tvalid && !m_tready && !rst;
            prev_vec   = {m_tuser, m_tlast, m_tvalid, m_tdata};
            @(posedge clk);
            #1;
            if (eng_on) begin
                for (int p = 0; p < NP; p++) begin
                    logic go;
                    go = (src_q[p].size() > 0) &&
                         ((s_tvalid[p] && !acc[p]) || !in_pkt[p] || ($urandom_range(99) >= gap_pct));
                    s_tvalid[p] = go;
                    if (go) begin
                        s_tdata[p*DW +: DW] = fill(src_q[p][0].tag);
                        s_tlast[p] = src_q[p][0].last;
                    end else begin
                        s_tlast[p] = 1'b0;
                    end
                end
                case (mode)
                    0:       m_tready = 1'b1;
                    1:       m_tready = ~m_tready;
                    default: m_tready = 1'($urandom_range(1));
                endcase
            end
        end
    end

    task automatic load_pkt(input int p, input int len, input bit add_exp, output logic [31:0] t0);
        t0 = {4'(p), 12'(pkt_seq), 16'd0};
        pkt_seq++;
        for (int b = 0; b < len; b++) begin
            src_q[p].push_back('{t0 + 32'(b), (b == len - 1)});
            if (add_exp) exp_q.push_back('{UB'(p), (b == len - 1), fill(t0 + 32'(b))});
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        for (int p = 0; p < NP; p++) begin
            src_q[p].delete();
            in_pkt[p] = 1'b0;
        end
        s_tvalid = '0;
        s_tlast  = '0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        chk("rst_mvalid", 64'(m_tvalid), 64'd0);
        chk("rst_mlast", 64'(m_tlast), 64'd0);
        chk("rst_muser", 64'(m_tuser), 64'd0);
        chk_w("rst_mdata", 640'(m_tdata), 640'd0);
        chk("rst_stready", 64'(s_tready), 64'd0);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic compare(input string nm);
        int c;
        int n;
        c = 0;
        while (c < 3000 && !(obs_q.size() >= exp_q.size() && src_q[0].size() == 0 &&
               src_q[1].size() == 0 && src_q[2].size() == 0 && src_q[3].size() == 0)) begin
            @(posedge clk);
            c++;
        end
        repeat (6) @(posedge clk);
        #2;
        chk({nm, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_b%0d_user", nm, i), 64'(obs_q[i].user), 64'(exp_q[i].user));
            chk($sformatf("%s_b%0d_last", nm, i), 64'(obs_q[i].last), 64'(exp_q[i].last));
            chk_w($sformatf("%s_b%0d_data", nm, i), 640'(obs_q[i].data), 640'(exp_q[i].data));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [18];
        logic [31:0] t;
        logic [31:0] ta, tb;
        int          plen [NP][$];
        logic [31:0] ptag [NP][$];
        int          total, ptr, pk, base;
        logic        found, reached;

        rst = 1'b1; s_tdata = '0; s_tvalid = '0; s_tlast = '0; m_tready = 1'b1;

        // Port2 3-beat packet, then all ports with 1-beat packets (rr_ptr starts at 3).
        vecs[0]  = '{4'b0100, 4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 1'b0, 3'd0, 16'h0000};
        vecs[1]  = '{4'b0100, 4'b0000, 8'h00, 1'b1, 4'b0100, 1'b0, 1'b0, 3'd0, 16'h0000};
        vecs[2]  = '{4'b0100, 4'b0000, 8'h01, 1'b1, 4'b0100, 1'b1, 1'b0, 3'd2, 16'h0200};
        vecs[3]  = '{4'b0100, 4'b0100, 8'h02, 1'b1, 4'b0100, 1'b1, 1'b0, 3'd2, 16'h0201};
        vecs[4]  = '{4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0000, 1'b1, 1'b1, 3'd2, 16'h0202};
        vecs[5]  = '{4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 1'b0, 3'd0, 16'h0000};
        vecs[6]  = '{4'b1111, 4'b1111, 8'h10, 1'b1, 4'b0000, 1'b0, 1'b0, 3'd0, 16'h0000};
        vecs[7]  = '{4'b1111, 4'b1111, 8'h10, 1'b1, 4'b1000, 1'b0, 1'b0, 3'd0, 16'h0000};
        vecs[8]  = '{4'b1111, 4'b1111, 8'h10, 1'b1, 4'b0000, 1'b1, 1'b1, 3'd3, 16'h0310};
        vecs[9]  = '{4'b1111, 4'b1111, 8'h10, 1'b1, 4'b0001, 1'b0, 1'b0, 3'd0, 16'h0000};
        vecs[10] = '{4'b1111, 4'b1111, 8'h10, 1'b1, 4'b0000, 1'b1, 1'b1, 3'd0, 16'h0010};
        vecs[11] = '{4'b1111, 4'b1111, 8'h10, 1'b1, 4'b0010, 1'b0, 1'b0, 3'd0, 16'h0000};
        vecs[12] = '{4'b1111, 4'b1111, 8'h10, 1'b1, 4'b0000, 1'b1, 1'b1, 3'd1, 16'h0110};
        vecs[13] = '{4'b1111, 4'b1111, 8'h10, 1'b1, 4'b0100, 1'b0, 1'b0, 3'd0, 16'h0000};
        vecs[14] = '{4'b1111, 4'b1111, 8'h10, 1'b1, 4'b0000, 1'b1, 1'b1, 3'd2, 16'h0210};
        vecs[15] = '{4'b1000, 4'b1000, 8'h10, 1'b1, 4'b1000, 1'b0, 1'b0, 3'd0, 16'h0000};
        vecs[16] = '{4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0000, 1'b1, 1'b1, 3'd3, 16'h0310};
        vecs[17] = '{4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 1'b0, 3'd0, 16'h0000};

        do_reset();
        for (int i = 0; i < 18; i++) begin
            @(posedge clk);
            #1;
            s_tvalid = vecs[i].tv;
            s_tlast  = vecs[i].tl;
            for (int p = 0; p < NP; p++) s_tdata[p*DW +: DW] = fill({16'h0000, 8'(p), vecs[i].dat});
            m_tready = vecs[i].mr;
            #3;
            chk($sformatf("vec%0d_stready", i), 64'(s_tready), 64'(vecs[i].str));
            chk($sformatf("vec%0d_mvalid", i), 64'(m_tvalid), 64'(vecs[i].mv));
            if (vecs[i].mv) begin
                chk($sformatf("vec%0d_mlast", i), 64'(m_tlast), 64'(vecs[i].ml));
                chk($sformatf("vec%0d_muser", i), 64'(m_tuser), 64'(vecs[i].mu));
                chk_w($sformatf("vec%0d_mdata", i), 640'(m_tdata), 640'(fill({16'h0000, vecs[i].md})));
            end
        end
        s_tvalid = '0;
        s_tlast  = '0;
        obs_q.delete();
        eng_on = 1'b1;

        // Higher port joins mid-packet, then a lower port joins mid-packet.
        do_reset();
        mode = 0; gap_pct = 0;
        load_pkt(0, 4, 1'b1, t);
        repeat (2) @(posedge clk);
        #2;
        load_pkt(1, 2, 1'b1, t);
        compare("t3a");
        load_pkt(2, 3, 1'b1, t);
        repeat (2) @(posedge clk);
        #2;
        load_pkt(0, 1, 1'b1, t);
        compare("t3b");

        // Downstream ready toggling through an 8-beat packet.
        mode = 1;
        load_pkt(1, 8, 1'b1, t);
        compare("t4");
        mode = 0;

        // Reset after two beats of a five-beat packet.
        do_reset();
        load_pkt(3, 5, 1'b0, t);
        base = acc_cnt[3];
        reached = 1'b0;
        for (int c = 0; c < 100 && !reached; c++) begin
            @(posedge clk);
            #2;
            reached = (acc_cnt[3] - base >= 2);
        end
        chk("t5_two_beats", 64'(reached), 64'd1);
        rst = 1'b1;
        for (int p = 0; p < NP; p++) begin
            src_q[p].delete();
            in_pkt[p] = 1'b0;
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        chk("t5_mvalid", 64'(m_tvalid), 64'd0);
        chk("t5_stready", 64'(s_tready), 64'd0);
        obs_q.delete();
        exp_q.delete();
        load_pkt(3, 1, 1'b0, ta);
        load_pkt(0, 1, 1'b0, tb);
        exp_q.push_back('{UB'(0), 1'b1, fill(tb)});
        exp_q.push_back('{UB'(3), 1'b1, fill(ta)});
        compare("t5_after");

`ifdef MUU_INARB_PKTCNT_EN
        do_reset();
        for (int k = 0; k < 5; k++) load_pkt(1, $urandom_range(1, 3), 1'b1, t);
        compare("t6a");
        for (int k = 0; k < 2; k++) load_pkt(3, $urandom_range(1, 3), 1'b1, t);
        compare("t6b");
        chk("t6_cnt0", 64'(pkt_count[0 +: 32]), 64'd0);
        chk("t6_cnt1", 64'(pkt_count[32 +: 32]), 64'd5);
        chk("t6_cnt2", 64'(pkt_count[64 +: 32]), 64'd0);
        chk("t6_cnt3", 64'(pkt_count[96 +: 32]), 64'd2);
`endif

        // Random backlogs with random gaps and downstream stalls, against a packet-level rotation model.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            mode = 2; gap_pct = 30;
            total = 0;
            for (int p = 0; p < NP; p++) begin
                plen[p].delete();
                ptag[p].delete();
                pk = $urandom_range(0, 5);
                for (int k = 0; k < pk; k++) begin
                    int len;
                    len = $urandom_range(1, 5);
                    load_pkt(p, len, 1'b0, t);
                    plen[p].push_back(len);
                    ptag[p].push_back(t);
                    total++;
                end
            end
            if (total == 0) begin
                load_pkt(2, 2, 1'b0, t);
                plen[2].push_back(2);
                ptag[2].push_back(t);
                total = 1;
            end
            ptr = 0;
            while (total > 0) begin
                int sel;
                int len;
                found = 1'b0;
                sel = 0;
                for (int k = 0; k < NP; k++) begin
                    if (!found && plen[(ptr + k) % NP].size() > 0) begin
                        sel = (ptr + k) % NP;
                        found = 1'b1;
                    end
                end
                len = plen[sel].pop_front();
                t = ptag[sel].pop_front();
                for (int b = 0; b < len; b++) exp_q.push_back('{UB'(sel), (b == len - 1), fill(t + 32'(b))});
                ptr = (sel + 1) % NP;
                total--;
            end
            compare($sformatf("rand%0d", r));
        end
        mode = 0; gap_pct = 0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
